fetch_stage: RTL

//  Instruction-fetch stage of the 16-bit microRISC core, directly upstream of control_unit/decode.

---
 rtl/fetch_stage.sv | 112 +++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one request to instruction memory in flight and
// buffers returned words in a 2-entry queue that feeds decode. EX redirects flush the queue.
module fetch_stage #(
  parameter int              XLEN     = 16,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              PC_STEP  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [15:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [15:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus2,
  output logic [3:0]      if_opcode,
  output logic [2:0]      if_funct
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic [1:0]      count;
  logic [XLEN-1:0] q_pc    [2];
  logic [15:0]     q_instr [2];

  logic fire, push, pop, redirect_act, wsel;

  assign fire         = imem_req_valid && imem_req_ready;
  assign redirect_act = redirect_valid && (state != IDLE);
  // A response that races a redirect is stale and never enters the queue.
  assign push         = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop          = if_valid && id_ready && !redirect_valid;
  // Slot for the incoming word, accounting for a same-cycle shift out of the head.
  assign wsel         = pop ? count[1] : count[0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (fire) state_nxt = WAIT;
      WAIT: begin
        if (imem_rsp_valid)      state_nxt = REQ;
        else if (redirect_valid) state_nxt = DROP;
      end
      DROP: if (imem_rsp_valid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == REQ) && (count < 2'd2) && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)            pc <= RESET_PC;
    else if (redirect_act) pc <= {redirect_pc[XLEN-1:1], 1'b0};
    else if (fire)         pc <= pc + STEP;
  end

  always_ff @(posedge clk) begin
    if (fire) inflight_pc <= pc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)            count <= 2'd0;
    else if (redirect_act) count <= 2'd0;
    else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage: head lives in slot 0, later writes override the shift.
  always_ff @(posedge clk) begin
    if (pop) begin
      q_pc[0]    <= q_pc[1];
      q_instr[0] <= q_instr[1];
    end
    if (push) begin
      q_pc[wsel]    <= inflight_pc;
      q_instr[wsel] <= imem_rsp_data;
    end
  end

  assign imem_addr   = pc;
  assign if_valid    = (count != 2'd0);
  assign if_instr    = if_valid ? q_instr[0] : 16'h0000;
  assign if_pc       = if_valid ? q_pc[0] : '0;
  assign if_pc_plus2 = if_valid ? (q_pc[0] + STEP) : '0;
  assign if_opcode   = if_instr[15:12];
  assign if_funct    = if_instr[2:0];

endmodule
